// File: rtl/fft_pkg.sv
// Shared definitions for the 64-point radix-8 FFT sequencer: FSM states,
// transform geometry and the butterfly slot record carried down the
// write-back delay line.
package fft_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        STG0 = 3'd1,
        DRN0 = 3'd2,
        STG1 = 3'd3,
        DRN1 = 3'd4,
        DONE = 3'd5
    } fft_state_t;

    localparam int FFT_N            = 64;
    localparam int FFT_RADIX        = 8;
    localparam int FFT_BFLY_PER_STG = 8;

    typedef struct packed {
        logic       vld;
        logic [0:0] stg;
        logic [2:0] idx;
    } fft_slot_t;

endpackage

// File: rtl/fft_ctrl_if.sv
// Handshake bundle between the FFT sequencer and its surroundings: the
// start/hold controls, status flags, the issue port feeding the twiddle
// generator and read port, and the write-back strobes.
interface fft_ctrl_if;

    logic       start;
    logic       hold;
    logic       busy;
    logic       done;
    logic       iss_vld;
    logic       iss_stg;
    logic [2:0] iss_idx;
    logic       wr_vld;
    logic       wr_stg;
    logic [2:0] wr_idx;

    modport master (
        input  start, hold,
        output busy, done, iss_vld, iss_stg, iss_idx, wr_vld, wr_stg, wr_idx
    );

    modport slave (
        output start, hold,
        input  busy, done, iss_vld, iss_stg, iss_idx, wr_vld, wr_stg, wr_idx
    );

endinterface

// File: rtl/fft_ctrl_dly.sv
// Fixed-latency delay line that follows each issued butterfly slot through
// the twiddle register and butterfly pipeline so it reappears as a
// write-back strobe exactly FFT_LAT cycles later.
module fft_ctrl_dly
    import fft_pkg::*;
#(
    parameter int FFT_LAT = 4
) (
    input  logic      clk,
    input  logic      clr,
    input  fft_slot_t din,
    output fft_slot_t dout
);

    fft_slot_t line [FFT_LAT];

    // Shift every cycle; clearing drops all in-flight slots at once.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < FFT_LAT; i++) begin
                line[i] <= '0;
            end
        end else begin
            line[0] <= din;
            for (int i = 1; i < FFT_LAT; i++) begin
                line[i] <= line[i-1];
            end
        end
    end

    assign dout = line[FFT_LAT-1];

endmodule

// File: rtl/fft_ctrl.sv
// Sequencer for the two-stage radix-8 FFT: issues the eight butterflies of
// each stage, waits for the last write-back of a stage before starting the
// next (in-place memory), and pulses done when stage 1 has fully landed.
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int FFT_LAT     = 4,
    parameter int FFT_NUM_STG = 2
) (
    input  logic      clk,
    input  logic      rst,
    fft_ctrl_if.master bus
);

    localparam logic [2:0] LAST_IDX = 3'(FFT_BFLY_PER_STG - 1);
    localparam logic       LAST_STG = 1'(FFT_NUM_STG - 1);

    fft_state_t state;
    logic [2:0] cnt;
    logic       issuing;
    logic       issue;
    logic       cur_stg;
    logic       last_wr_stg0;
    logic       last_wr_stg1;
    fft_slot_t  iss_slot;
    fft_slot_t  wr_slot;

    assign issuing = (state == STG0) || (state == STG1);
    assign issue   = issuing && !bus.hold;
    assign cur_stg = (state == STG1) || (state == DRN1);

    assign last_wr_stg0 = wr_slot.vld && (wr_slot.stg == 1'b0)     && (wr_slot.idx == LAST_IDX);
    assign last_wr_stg1 = wr_slot.vld && (wr_slot.stg == LAST_STG) && (wr_slot.idx == LAST_IDX);

    // Main sequencer: issue counter advances only on real issues and wraps
    // to 0 after the last butterfly of a stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) state <= STG0;
                end
                STG0: begin
                    if (issue) begin
                        cnt <= cnt + 3'd1;
                        if (cnt == LAST_IDX) state <= DRN0;
                    end
                end
                DRN0: begin
                    if (last_wr_stg0) state <= STG1;
                end
                STG1: begin
                    if (issue) begin
                        cnt <= cnt + 3'd1;
                        if (cnt == LAST_IDX) state <= DRN1;
                    end
                end
                DRN1: begin
                    if (last_wr_stg1) state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

    assign iss_slot = '{vld: issue, stg: cur_stg, idx: cnt};

    fft_ctrl_dly #(
        .FFT_LAT (FFT_LAT)
    ) u_dly (
        .clk  (clk),
        .clr  (rst),
        .din  (iss_slot),
        .dout (wr_slot)
    );

    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
    assign bus.iss_vld = issue;
    assign bus.iss_stg = cur_stg;
    assign bus.iss_idx = cnt;
    assign bus.wr_vld  = wr_slot.vld;
    assign bus.wr_stg  = wr_slot.stg;
    assign bus.wr_idx  = wr_slot.idx;

endmodule

// File: tb/tb_fft_ctrl.sv
// Bench for fft_ctrl: three instances (L=4, 1, 7) driven in lockstep and
// compared cycle by cycle with a timeline model built from the transform
// rules, plus table constants and hand-written multi-cycle sequences.
module tb_fft_ctrl;
    import fft_pkg::*;

    localparam int NDUT    = 3;
    localparam int HORIZON = 72;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       iss_vld;
        logic       iss_stg;
        logic [2:0] iss_idx;
        logic       wr_vld;
        logic       wr_stg;
        logic [2:0] wr_idx;
    } obs_t;

    typedef struct {
        int holdFrom;
        int holdTo;
        int extraStart;
        int expDone4;
        int expDone1;
        int expDone7;
        int expS1First4;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic start_d;
    logic hold_d;

    obs_t expTab  [NDUT][HORIZON];
    logic holdPat [HORIZON];
    int   extraStart;
    int   doneAt [NDUT];
    int   s1At   [NDUT];
    int   w7At   [NDUT];
    int   issN   [NDUT];
    int   wrN    [NDUT];
    int   checkCount = 0;
    int   failCount  = 0;
    vec_t vectors [5];

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    fft_ctrl_if bus4 ();
    fft_ctrl_if bus1 ();
    fft_ctrl_if bus7 ();

    assign bus4.start = start_d;
    assign bus4.hold  = hold_d;
    assign bus1.start = start_d;
    assign bus1.hold  = hold_d;
    assign bus7.start = start_d;
    assign bus7.hold  = hold_d;

    fft_ctrl #(.FFT_LAT(4), .FFT_NUM_STG(2)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    fft_ctrl #(.FFT_LAT(1), .FFT_NUM_STG(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    fft_ctrl #(.FFT_LAT(7), .FFT_NUM_STG(2)) dut7 (.clk(clk), .rst(rst), .bus(bus7));

    function automatic int latOf(input int di);
        case (di)
            0:       return 4;
            1:       return 1;
            default: return 7;
        endcase
    endfunction

    function automatic obs_t readDut(input int di);
        obs_t o;
        case (di)
            0: o = '{bus4.busy, bus4.done, bus4.iss_vld, bus4.iss_stg, bus4.iss_idx,
                     bus4.wr_vld, bus4.wr_stg, bus4.wr_idx};
            1: o = '{bus1.busy, bus1.done, bus1.iss_vld, bus1.iss_stg, bus1.iss_idx,
                     bus1.wr_vld, bus1.wr_stg, bus1.wr_idx};
            default: o = '{bus7.busy, bus7.done, bus7.iss_vld, bus7.iss_stg, bus7.iss_idx,
                           bus7.wr_vld, bus7.wr_stg, bus7.wr_idx};
        endcase
        return o;
    endfunction

    task automatic checkOutput(input string name, input int di, input int c,
                               input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s dut%0d(L=%0d) cycle %0d: got %0h expected %0h",
                     name, di, latOf(di), c, act, exp);
        end
    endtask

    // Timeline model: each stage issues its 8 butterflies on the non-hold
    // cycles, the next stage opens the cycle after the previous stage's last
    // write (last issue + L), and write-back mirrors the issue port L later.
    task automatic buildModel(input int di);
        int   lat;
        int   c;
        int   lastIss;
        int   lastWr;
        obs_t e;
        lat     = latOf(di);
        lastIss = 0;
        for (int t = 0; t < HORIZON; t++) expTab[di][t] = '0;
        c = 1;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 8; k++) begin
                while (c < HORIZON && holdPat[c]) begin
                    e = '0; e.busy = 1'b1; e.iss_stg = s[0]; e.iss_idx = k[2:0];
                    expTab[di][c] = e;
                    c++;
                end
                if (c < HORIZON) begin
                    e = '0; e.busy = 1'b1; e.iss_vld = 1'b1; e.iss_stg = s[0]; e.iss_idx = k[2:0];
                    expTab[di][c] = e;
                end
                lastIss = c;
                c++;
            end
            lastWr = lastIss + lat;
            while (c <= lastWr && c < HORIZON) begin
                e = '0; e.busy = 1'b1; e.iss_stg = s[0];
                expTab[di][c] = e;
                c++;
            end
        end
        if (c < HORIZON) begin
            e = '0; e.busy = 1'b1; e.done = 1'b1;
            expTab[di][c] = e;
        end
        for (int t = lat; t < HORIZON; t++) begin
            expTab[di][t].wr_vld = expTab[di][t-lat].iss_vld;
            expTab[di][t].wr_stg = expTab[di][t-lat].iss_stg;
            expTab[di][t].wr_idx = expTab[di][t-lat].iss_idx;
        end
    endtask

    task automatic applyStimulus(input int c);
        start_d = (c == 0) || (c == extraStart);
        hold_d  = holdPat[c];
    endtask

    // One transform starting at cycle 0, every cycle compared on all DUTs.
    task automatic runScenario(input bit doReset);
        obs_t o;
        for (int di = 0; di < NDUT; di++) begin
            buildModel(di);
            doneAt[di] = -1; s1At[di] = -1; w7At[di] = -1; issN[di] = 0; wrN[di] = 0;
        end
        if (doReset) begin
            @(posedge clk); #1;
            rst = 1'b1; start_d = 1'b0; hold_d = 1'b0;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < HORIZON; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            applyStimulus(c);
            @(negedge clk);
            for (int di = 0; di < NDUT; di++) begin
                o = readDut(di);
                checkOutput("outputs", di, c, 32'(o), 32'(expTab[di][c]));
                if (o.done && doneAt[di] < 0) doneAt[di] = c;
                if (o.iss_vld && o.iss_stg && s1At[di] < 0) s1At[di] = c;
                if (o.wr_vld && !o.wr_stg && o.wr_idx == 3'd7 && w7At[di] < 0) w7At[di] = c;
                if (o.iss_vld) issN[di]++;
                if (o.wr_vld) wrN[di]++;
            end
        end
        start_d = 1'b0;
        hold_d  = 1'b0;
        for (int di = 0; di < NDUT; di++) begin
            checkOutput("issue_count", di, HORIZON, 32'(issN[di]), 32'd16);
            checkOutput("write_count", di, HORIZON, 32'(wrN[di]), 32'd16);
            checkOutput("s1_after_s0_last_write", di, s1At[di],
                        32'(s1At[di] > w7At[di] && w7At[di] > 0), 32'd1);
        end
    endtask

    task automatic runVector(input vec_t v, input bit doReset);
        for (int c = 0; c < HORIZON; c++) holdPat[c] = (c >= v.holdFrom) && (c <= v.holdTo);
        extraStart = v.extraStart;
        runScenario(doReset);
        checkOutput("done_cycle", 0, 0, 32'(doneAt[0]), 32'(v.expDone4));
        checkOutput("done_cycle", 1, 0, 32'(doneAt[1]), 32'(v.expDone1));
        checkOutput("done_cycle", 2, 0, 32'(doneAt[2]), 32'(v.expDone7));
        checkOutput("s1_first_issue", 0, 0, 32'(s1At[0]), 32'(v.expS1First4));
    endtask

    initial begin
        obs_t o;
        rst = 1'b1; start_d = 1'b0; hold_d = 1'b0; extraStart = -1;

        vectors[0] = '{-1, -1, -1, 25, 19, 31, 13};
        vectors[1] = '{ 3,  5, -1, 28, 22, 34, 16};
        vectors[2] = '{ 8,  8, -1, 26, 20, 32, 14};
        vectors[3] = '{ 9, 11, -1, 25, 21, 31, 13};
        vectors[4] = '{-1, -1, 10, 25, 19, 31, 13};

        repeat (2) @(posedge clk);

        for (int i = 0; i < 5; i++) runVector(vectors[i], 1'b1);

        // Randomized hold patterns and stray start pulses against the model.
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < HORIZON; c++)
                holdPat[c] = (c >= 1) && (c <= 30) && ($urandom_range(0, 3) == 0);
            extraStart = int'($urandom_range(2, 15));
            runScenario(1'b1);
        end

        // Back-to-back: start held high, the next transform begins at the
        // first IDLE cycle after DONE.
        @(posedge clk); #1;
        rst = 1'b1; start_d = 1'b0; hold_d = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; start_d = 1'b1;
        for (int c = 0; c < 36; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            o = readDut(0);
            if (c == 26) checkOutput("b2b_idle_gap", 0, c, 32'({o.busy, o.iss_vld}), 32'd0);
            if (c == 27) checkOutput("b2b_first_issue", 0, c, 32'({o.iss_vld, o.iss_stg, o.iss_idx}), 32'b10000);
            o = readDut(1);
            if (c == 20) checkOutput("b2b_idle_gap", 1, c, 32'({o.busy, o.iss_vld}), 32'd0);
            if (c == 21) checkOutput("b2b_first_issue", 1, c, 32'({o.iss_vld, o.iss_stg, o.iss_idx}), 32'b10000);
            o = readDut(2);
            if (c == 32) checkOutput("b2b_idle_gap", 2, c, 32'({o.busy, o.iss_vld}), 32'd0);
            if (c == 33) checkOutput("b2b_first_issue", 2, c, 32'({o.iss_vld, o.iss_stg, o.iss_idx}), 32'b10000);
        end
        start_d = 1'b0;

        // Reset mid-transform at cycle 14: everything quiet afterwards.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start_d = 1'b1;
        for (int c = 1; c < 24; c++) begin
            @(posedge clk); #1;
            start_d = 1'b0;
            rst = (c == 14);
            @(negedge clk);
            if (c >= 15) begin
                for (int di = 0; di < NDUT; di++) begin
                    o = readDut(di);
                    checkOutput("quiet_after_reset", di, c, 32'({o.busy, o.iss_vld, o.wr_vld}), 32'd0);
                end
            end
        end
        rst = 1'b0;
        runVector(vectors[0], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/fft_ctrl.md
# fft_ctrl

Sequencer for the 64-point radix-8 DIT FFT core: two stages of eight butterflies each. On `start` it issues the 16 butterfly slots (stage, index) in order to the twiddle generator and the in-place data memory read port. It tracks each slot through the fixed-latency butterfly pipeline to produce write-back strobes. It holds stage 1 until every stage-0 write has landed, then pulses `done`.

## Interface
- `FFT_LAT`, default 4: cycles from issue to write-back, covering twiddle register and butterfly pipeline. Legal range is ≥1.
- `FFT_NUM_STG`, default 2: number of radix-8 stages. Fixed at 2 for 64 points.
- `clk` in, 1: clock.
- `rst` in, 1: reset; synchronous and active-high.
- `start` in, 1: begin one transform. Sampled only in IDLE.
- `hold` in, 1: suspend issue. The write-back pipeline keeps advancing.
- `busy` out, 1: state ≠ IDLE.
- `done` out, 1: one-cycle pulse when the transform is complete.
- `iss_vld` out, 1: a butterfly slot is issued this cycle. Drives the twiddle generator `vld_in` and the memory read enable.
- `iss_stg` out, 1: stage of the issued slot. Drives the twiddle generator `fft_stg`.
- `iss_idx` out, 3: butterfly index 0..7. Drives the twiddle generator `fft_idx`.
- `wr_vld` out, 1: write-back strobe for the slot issued `FFT_LAT` cycles earlier.
- `wr_stg` out, 1: stage of the write-back slot.
- `wr_idx` out, 3: butterfly index of the write-back slot.

## Operation
- States: IDLE, STG0, DRN0, STG1, DRN1, DONE.
- IDLE → STG0 when `start`=1. Otherwise stay.
- STG0 and STG1, issue behaviour:
  - `iss_vld` = !`hold`.
  - `iss_idx` = issue counter.
  - Counter increments on each issue.
- STG0 → DRN0 on the issue with `iss_idx`=7. The counter wraps to 0.
- DRN0 → STG1 in the cycle after `wr_vld`=1 with `wr_stg`=0 and `wr_idx`=7.
- STG1 → DRN1 on the issue with `iss_idx`=7.
- DRN1 → DONE in the cycle after `wr_vld`=1 with `wr_stg`=1 and `wr_idx`=7.
- DONE → IDLE unconditionally. `done`=1 only in DONE.
- `iss_stg` = 0 in STG0/DRN0 and 1 in STG1/DRN1.
- `iss_vld`=0 in every non-issue state.
- Write-back path: a delay line of `FFT_LAT` entries, each {vld, stg, idx}.
  - Loaded every cycle from {`iss_vld`, `iss_stg`, `iss_idx`}.
  - Output drives {`wr_vld`, `wr_stg`, `wr_idx`}.
  - Stage/index fields pass through untouched when vld=0. Consumers qualify them with `wr_vld`.
- `start` while `busy` is ignored. No queuing.
- `hold` in a DRN, DONE or IDLE state has no effect.
- `hold` asserted on the cycle idx 7 would issue: idx 7 issues later, on the first cycle `hold`=0.

## Timing
- Reset (`rst`=1 at a rising edge):
  - state = IDLE, issue counter = 0, all delay-line entries cleared.
  - `busy`, `done`, `iss_vld`, `wr_vld` = 0.
  - `iss_stg`, `iss_idx`, `wr_stg`, `wr_idx` = 0.
- Reset mid-transform: same result in one cycle. In-flight slots are discarded and no `wr_vld` appears afterwards. Memory contents are undefined.
- All outputs are registered or decoded from registered state. There is no combinational path from `start`/`hold` to the issue outputs except `iss_vld` gating by `hold`.
- With `start` sampled at cycle 0 and `hold`=0 throughout:
  - STG0 issues idx 0..7 in cycles 1..8.
  - Stage-0 writes occur in cycles 1+L..8+L, where L=`FFT_LAT`.
  - STG1 issues in cycles 9+L..16+L.
  - Stage-1 writes occur in cycles 9+2L..16+2L.
  - `done` in cycle 17+2L; back in IDLE in cycle 18+2L.
  - For L=4: `done` in cycle 25.
- `busy` is high in cycles 1..17+2L inclusive.
- Each `hold` cycle during STG0/STG1 delays all later events by one cycle.
- Back-to-back: `start` held high through DONE starts a new transform at the first IDLE cycle. Gap of 1 cycle.

## Structure
- Shared package `fft_pkg`:
  - state enumeration;
  - `FFT_N`=64, `FFT_RADIX`=8, `FFT_BFLY_PER_STG`=8;
  - slot struct {vld, stg[0:0], idx[2:0]}.
- Sub-module `fft_ctrl_dly`: parameterised `FFT_LAT`-deep shift register of slot structs with synchronous active-high clear. Instantiated once.
- FSM and issue counter live in `fft_ctrl`.

## Test plan
- Reset, then `start` pulse at cycle 0 with L=4 and no `hold`:
  - `iss_idx` 0..7 with `iss_stg`=0 in cycles 1..8;
  - stage-0 `wr_vld` in cycles 5..12;
  - `iss_stg`=1 issues in cycles 13..20;
  - stage-1 `wr_vld` in cycles 17..24;
  - `done` only in cycle 25; `busy` only in cycles 1..25.
- `hold`=1 for cycles 3..5 during STG0: idx 2 issues at cycle 6, idx 7 at cycle 11. Stage-1 first issue moves to cycle 16; `done` at cycle 28.
- `start` pulsed at cycle 10 during a transform: ignored, and exactly 16 issues and 16 writes occur. `start` held continuously: a second transform's first issue appears in cycle 27.
- `rst` asserted at cycle 14 (mid-STG1): from cycle 15 `busy`=0, `iss_vld`=0 and `wr_vld`=0 for at least L+1 cycles. A fresh `start` then reproduces the first scenario exactly.
- Parameter sweep L=1 and L=7: `done` at cycles 19 and 31 respectively. No stage-1 issue precedes the stage-0 idx-7 write. `wr_idx` sequence equals `iss_idx` sequence delayed by L.
